// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: gray/binary conversion and depth derived from pointer width.
package fifo_pkg;

  function automatic int unsigned depth(input int unsigned size);
    return 32'd1 << (size - 32'd1);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = 32'd0;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational gray-to-binary converter built on the shared package function.
module gray_to_binary
  import fifo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  assign bin_o = WIDTH'(gray2bin(32'(gray_i)));

endmodule

// File: rtl/sync.sv
// Two-flop synchronizer for a multi-bit gray-coded bus.
module sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/full_gen.sv
// Write-side pointer and full/almost-full generation for an async FIFO.
// Optional sticky overflow flag enabled by defining FIFO_OVERFLOW_FLAG_EN.
module full_gen
  import fifo_pkg::*;
#(
  parameter int SIZE               = 4,
  parameter int ALMOST_FULL_MARGIN = 1
) (
  input  logic            write_clock,
  input  logic            reset,
  input  logic            write_request,
  input  logic [SIZE-1:0] read_gray_pointer,
  output logic            write_enable,
  output logic [SIZE-2:0] write_address,
  output logic [SIZE-1:0] write_gray,
  output logic            full_flag,
  output logic            almost_full_flag,
  output logic            overflow_flag
);

  localparam int unsigned DEPTH = depth(SIZE);

  logic [SIZE-1:0] wbin_q;
  logic [SIZE-1:0] wbin_d;
  logic [SIZE-1:0] wgray_q;
  logic [SIZE-1:0] wgray_d;
  logic [SIZE-1:0] rgray_sync;
  logic [SIZE-1:0] rbin_sync;
  logic [SIZE-1:0] full_cmp;
  logic [SIZE-1:0] fill_d;
  logic            full_q;
  logic            full_d;
  logic            afull_q;
  logic            afull_d;

  sync #(
    .WIDTH (SIZE)
  ) u_sync (
    .clk_i (write_clock),
    .rst_i (reset),
    .d_i   (read_gray_pointer),
    .q_o   (rgray_sync)
  );

  gray_to_binary #(
    .WIDTH (SIZE)
  ) u_gray_to_binary (
    .gray_i (rgray_sync),
    .bin_o  (rbin_sync)
  );

  assign write_enable = write_request & ~full_q;

  // Flags look ahead at the post-write pointer so they assert on the filling edge.
  always_comb begin
    wbin_d   = wbin_q + {{(SIZE-1){1'b0}}, write_enable};
    wgray_d  = SIZE'(bin2gray(32'(wbin_d)));
    full_cmp = {~rgray_sync[SIZE-1:SIZE-2], rgray_sync[SIZE-3:0]};
    full_d   = (wgray_d == full_cmp);
    fill_d   = wbin_d - rbin_sync;
    afull_d  = (32'(fill_d) + 32'(ALMOST_FULL_MARGIN)) >= 32'(DEPTH);
  end

  // Pointer, gray copy and flag registers.
  always_ff @(posedge write_clock or posedge reset) begin
    if (reset) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      afull_q <= afull_d;
    end
  end

  assign write_address    = wbin_q[SIZE-2:0];
  assign write_gray       = wgray_q;
  assign full_flag        = full_q;
  assign almost_full_flag = afull_q;

`ifdef FIFO_OVERFLOW_FLAG_EN
  logic overflow_q;

  // Sticky: only reset clears it.
  always_ff @(posedge write_clock or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (write_request & full_q) begin
      overflow_q <= 1'b1;
    end else begin
      overflow_q <= overflow_q;
    end
  end

  assign overflow_flag = overflow_q;
`else
  assign overflow_flag = 1'b0;
`endif

endmodule

// File: tb/tb_full_gen.sv
// Scoreboard bench for full_gen (SIZE=4, depth 8, margin 1).
module tb_full_gen;

  logic       write_clock = 1'b0;
  logic       reset;
  logic       write_request;
  logic [3:0] read_gray_pointer;
  logic       write_enable;
  logic [2:0] write_address;
  logic [3:0] write_gray;
  logic       full_flag;
  logic       almost_full_flag;
  logic       overflow_flag;

`ifdef FIFO_OVERFLOW_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  full_gen #(
    .SIZE               (4),
    .ALMOST_FULL_MARGIN (1)
  ) dut (
    .write_clock       (write_clock),
    .reset             (reset),
    .write_request     (write_request),
    .read_gray_pointer (read_gray_pointer),
    .write_enable      (write_enable),
    .write_address     (write_address),
    .write_gray        (write_gray),
    .full_flag         (full_flag),
    .almost_full_flag  (almost_full_flag),
    .overflow_flag     (overflow_flag)
  );

  always #5 write_clock = ~write_clock;

  typedef struct {
    logic [2:0] addr;
    logic [3:0] gray;
    logic       full;
    logic       afull;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int         m_wptr;
  logic [3:0] m_s1;
  logic [3:0] m_s2;
  logic       m_full;
  logic       m_afull;
  logic       m_ovf;
  logic       last_we;

  function automatic logic [3:0] b2g(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int g2b(input logic [3:0] g);
    int b;
    b = 0;
    for (int i = 3; i >= 0; i--) begin
      b = b | ((((b >> (i + 1)) & 1) ^ int'(g[i])) << i);
    end
    return b;
  endfunction

  task automatic model_reset();
    m_wptr  = 0;
    m_s1    = 4'd0;
    m_s2    = 4'd0;
    m_full  = 1'b0;
    m_afull = 1'b0;
    m_ovf   = 1'b0;
    sb.delete();
  endtask

  // One write_clock cycle: drive at negedge, predict, compare after the rising edge.
  task automatic cycle(input logic req, input logic [3:0] rg);
    exp_t e;
    int   wnext;
    int   fill;
    @(negedge write_clock);
    write_request     = req;
    read_gray_pointer = rg;
    #1;
    last_we = req && !m_full;
    checks++;
    if (write_enable !== last_we) begin
      errors++;
      $display("FAIL write_enable: got %b expected %b", write_enable, last_we);
    end
    wnext = (m_wptr + (last_we ? 1 : 0)) % 16;
    fill  = (wnext - g2b(m_s2) + 16) % 16;
    if (OVF_EN && req && m_full) m_ovf = 1'b1;
    m_full  = (fill == 8);
    m_afull = ((8 - fill) <= 1);
    m_s2    = m_s1;
    m_s1    = rg;
    m_wptr  = wnext;
    e.addr  = 3'(m_wptr);
    e.gray  = b2g(m_wptr);
    e.full  = m_full;
    e.afull = m_afull;
    e.ovf   = m_ovf;
    sb.push_back(e);
    @(posedge write_clock);
    #1;
    e = sb.pop_front();
    checks++;
    if (write_address !== e.addr) begin
      errors++;
      $display("FAIL sb_addr: got %0d expected %0d", write_address, e.addr);
    end
    checks++;
    if (write_gray !== e.gray) begin
      errors++;
      $display("FAIL sb_gray: got %b expected %b", write_gray, e.gray);
    end
    checks++;
    if (full_flag !== e.full) begin
      errors++;
      $display("FAIL sb_full: got %b expected %b", full_flag, e.full);
    end
    checks++;
    if (almost_full_flag !== e.afull) begin
      errors++;
      $display("FAIL sb_afull: got %b expected %b", almost_full_flag, e.afull);
    end
    checks++;
    if (overflow_flag !== e.ovf) begin
      errors++;
      $display("FAIL sb_ovf: got %b expected %b", overflow_flag, e.ovf);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({write_enable, write_address, write_gray, full_flag, almost_full_flag, overflow_flag} !== 11'd0) begin
      errors++;
      $display("FAIL %s: we=%b addr=%0d gray=%b full=%b afull=%b ovf=%b expected all 0",
               tag, write_enable, write_address, write_gray, full_flag, almost_full_flag, overflow_flag);
    end
  endtask

  task automatic test_reset();
    reset             = 1'b0;
    write_request     = 1'b0;
    read_gray_pointer = 4'd0;
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_all_zero("reset_state");
    @(negedge write_clock);
    @(negedge write_clock);
    reset = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (write_address !== 3'(i)) begin
        errors++;
        $display("FAIL fill_addr: got %0d expected %0d", write_address, i);
      end
      cycle(1'b1, 4'd0);
      if (i == 6) begin
        checks++;
        if (almost_full_flag !== 1'b1 || full_flag !== 1'b0) begin
          errors++;
          $display("FAIL fill_afull7: afull=%b full=%b expected 1 0", almost_full_flag, full_flag);
        end
      end
    end
    checks++;
    if (full_flag !== 1'b1 || write_gray !== 4'b1100) begin
      errors++;
      $display("FAIL fill_full8: full=%b gray=%b expected 1 1100", full_flag, write_gray);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'd0);
    checks++;
    if (write_address !== 3'd0 || write_gray !== 4'b1100 || overflow_flag !== OVF_EN) begin
      errors++;
      $display("FAIL overflow: addr=%0d gray=%b ovf=%b expected 0 1100 %b",
               write_address, write_gray, overflow_flag, OVF_EN);
    end
  endtask

  task automatic test_release();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 4'b0001);
      checks++;
      if (full_flag !== (k < 2 ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL release_edge%0d: full=%b expected %b", k + 1, full_flag, (k < 2));
      end
    end
    checks++;
    if (write_address !== 3'd0) begin
      errors++;
      $display("FAIL release_addr: got %0d expected 0", write_address);
    end
    cycle(1'b1, 4'b0001);
    checks++;
    if (full_flag !== 1'b1) begin
      errors++;
      $display("FAIL release_refull: full=%b expected 1", full_flag);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) cycle(1'b0, b2g(4));
    checks++;
    if (full_flag !== 1'b0 || almost_full_flag !== 1'b0) begin
      errors++;
      $display("FAIL mid_fill5: full=%b afull=%b expected 0 0", full_flag, almost_full_flag);
    end
    @(negedge write_clock);
    #2;
    reset         = 1'b1;
    write_request = 1'b0;
    #1;
    model_reset();
    check_all_zero("mid_reset_async");
    write_request     = 1'b1;
    read_gray_pointer = 4'd0;
    @(posedge write_clock);
    #1;
    checks++;
    if (write_address !== 3'd0 || write_gray !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset_write: addr=%0d gray=%b expected 0 0000", write_address, write_gray);
    end
    @(negedge write_clock);
    reset         = 1'b0;
    write_request = 1'b0;
    cycle(1'b0, 4'd0);
    checks++;
    if (write_address !== 3'd0) begin
      errors++;
      $display("FAIL mid_first_addr: got %0d expected 0", write_address);
    end
    cycle(1'b1, 4'd0);
  endtask

  task automatic test_wrap();
    int         rp;
    int         writes;
    logic       seen;
    logic [3:0] prev;
    int         ones;
    test_reset();
    rp     = 0;
    writes = 0;
    seen   = 1'b0;
    for (int c = 0; c < 100 && writes < 20; c++) begin
      prev = write_gray;
      cycle(1'b1, b2g(rp));
      if (last_we) writes++;
      ones = $countones(prev ^ write_gray);
      checks++;
      if (ones != (last_we ? 1 : 0)) begin
        errors++;
        $display("FAIL wrap_onebit: %b -> %b changed %0d bits, write=%b", prev, write_gray, ones, last_we);
      end
      if (write_gray === 4'b1000) seen = 1'b1;
      if (rp + 3 < writes) rp++;
    end
    checks++;
    if (writes < 20) begin
      errors++;
      $display("FAIL wrap_budget: got %0d writes expected 20", writes);
    end
    checks++;
    if (!seen || write_gray !== b2g(20)) begin
      errors++;
      $display("FAIL wrap_gray: seen1000=%b final=%b expected 1 %b", seen, write_gray, b2g(20));
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
